// File: rtl/key_matrix_scan_module.sv
// Keypad matrix reader: strobe-paced active-low column scan, per-scan key
// classification, whole-scan debounce and single-key press reporting.
module key_matrix_scan_module #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DEBOUNCE = 3,
    parameter int CODE_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1pps,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   column_o,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_pressed_o,
    output logic              multi_o
);
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [CIDX_W-1:0] LAST_COL = CIDX_W'(COLS - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE);

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
    typedef enum logic [1:0] {ST_RELEASED, ST_PRESSED, ST_MULTI} state_e;

    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [CIDX_W-1:0] col_idx_q, col_idx_d;
    logic [COLS-1:0]   column_q, column_d;
    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;
    cls_e              prev_cls_q, prev_cls_d;
    logic [CODE_W-1:0] prev_code_q, prev_code_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_pressed_q, key_pressed_d;
    logic              multi_q, multi_d;

    logic [1:0]        col_cnt, base_cnt, merged_cnt;
    logic [2:0]        sum_cnt;
    logic [CODE_W-1:0] col_code, merged_code;
    cls_e              scan_cls;
    logic              same_cls, accept;

    // Scan sampling, per-scan accumulation and whole-scan debounce.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        col_cnt  = 2'd0;
        col_code = '0;
        // Walk rows downwards so the lowest pressed row is the one kept.
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                col_code = CODE_W'(r * COLS + int'(col_idx_q));
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
            end
        end

        base_cnt   = (col_idx_q == '0) ? 2'd0 : acc_cnt_q;
        sum_cnt    = {1'b0, base_cnt} + {1'b0, col_cnt};
        merged_cnt = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        if (base_cnt == 2'd0 || (col_cnt != 2'd0 && col_code < acc_code_q))
            merged_code = col_code;
        else
            merged_code = acc_code_q;

        case (merged_cnt)
            2'd0:    scan_cls = CLS_NONE;
            2'd1:    scan_cls = CLS_SINGLE;
            default: scan_cls = CLS_MULTI;
        endcase
        same_cls = (scan_cls == prev_cls_q) &&
                   (scan_cls != CLS_SINGLE || merged_code == prev_code_q);

        col_idx_d   = col_idx_q;
        acc_cnt_d   = acc_cnt_q;
        acc_code_d  = acc_code_q;
        prev_cls_d  = prev_cls_q;
        prev_code_d = prev_code_q;
        deb_cnt_d   = deb_cnt_q;
        accept      = 1'b0;

        if (p1pps) begin
            acc_cnt_d  = merged_cnt;
            acc_code_d = merged_code;
            col_idx_d  = (col_idx_q == LAST_COL) ? '0 : col_idx_q + CIDX_W'(1);
            if (col_idx_q == LAST_COL) begin
                if (same_cls) begin
                    if (deb_cnt_q != DEB_MAX) begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                        accept    = (deb_cnt_d == DEB_MAX);
                    end
                end else begin
                    prev_cls_d  = scan_cls;
                    prev_code_d = merged_code;
                    deb_cnt_d   = DEB_W'(1);
                    accept      = (DEBOUNCE == 1);
                end
            end
        end

        column_d = ~(COLS'(1) << col_idx_d);
    end

    // Press/multi state machine; reacts to accepted classifications only.
    always_comb begin
        state_d       = state_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;
        multi_d       = multi_q;
        if (accept) begin
            case (state_q)
                ST_RELEASED: begin
                    if (scan_cls == CLS_SINGLE) begin
                        key_code_d    = merged_code;
                        key_valid_d   = 1'b1;
                        key_pressed_d = 1'b1;
                        state_d       = ST_PRESSED;
                    end else if (scan_cls == CLS_MULTI) begin
                        multi_d = 1'b1;
                        state_d = ST_MULTI;
                    end
                end
                ST_PRESSED: begin
                    if (scan_cls == CLS_NONE) begin
                        key_pressed_d = 1'b0;
                        state_d       = ST_RELEASED;
                    end else if (scan_cls == CLS_MULTI || merged_code != key_code_q) begin
                        key_pressed_d = 1'b0;
                        multi_d       = 1'b1;
                        state_d       = ST_MULTI;
                    end
                end
                ST_MULTI: begin
                    if (scan_cls == CLS_NONE) begin
                        multi_d = 1'b0;
                        state_d = ST_RELEASED;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only; synchronizer
    // resets to all-ones so no key appears pressed right after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            row_meta_q    <= '1;
            row_sync_q    <= '1;
            col_idx_q     <= '0;
            column_q      <= '1;
            acc_cnt_q     <= 2'd0;
            acc_code_q    <= '0;
            prev_cls_q    <= CLS_NONE;
            prev_code_q   <= '0;
            deb_cnt_q     <= '0;
            state_q       <= ST_RELEASED;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            multi_q       <= 1'b0;
        end else begin
            row_meta_q    <= row_i;
            row_sync_q    <= row_meta_q;
            col_idx_q     <= col_idx_d;
            column_q      <= column_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_code_q    <= acc_code_d;
            prev_cls_q    <= prev_cls_d;
            prev_code_q   <= prev_code_d;
            deb_cnt_q     <= deb_cnt_d;
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            multi_q       <= multi_d;
        end
    end

    assign column_o      = column_q;
    assign key_code_o    = key_code_q;
    assign key_valid_o   = key_valid_q;
    assign key_pressed_o = key_pressed_q;
    assign multi_o       = multi_q;

endmodule

// File: tb/tb_key_matrix_scan_module.sv
// Directed bench for key_matrix_scan_module: a keypad model drives row_i from
// column_o and a held-key mask; p1pps pulses every 8 clocks.
module tb_key_matrix_scan_module;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       p1pps = 1'b0;
    logic [3:0] row_i;
    logic [3:0] column_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_pressed_o;
    logic       multi_o;

    logic [15:0] keys = '0;
    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    key_matrix_scan_module #(.ROWS(4), .COLS(4), .DEBOUNCE(3), .CODE_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p1pps        (p1pps),
        .row_i        (row_i),
        .column_o     (column_o),
        .key_code_o   (key_code_o),
        .key_valid_o  (key_valid_o),
        .key_pressed_o(key_pressed_o),
        .multi_o      (multi_o)
    );

    always #5 clk = ~clk;

    // Key k sits at row k/4, column k%4 and pulls its row low when its column is driven.
    always_comb begin
        row_i = '1;
        for (int k = 0; k < 16; k++)
            if (keys[k] && !column_o[k % 4]) row_i[k / 4] = 1'b0;
    end

    always @(negedge clk) if (key_valid_o === 1'b1) valid_cnt <= valid_cnt + 1;

    task automatic strobe();
        repeat (7) @(negedge clk);
        p1pps = 1'b1;
        @(negedge clk);
        p1pps = 1'b0;
    endtask

    task automatic scan();
        repeat (4) strobe();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_i = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        checks++; if (column_o !== 4'b1111) begin errors++; $display("FAIL reset_column: got %b expected 1111", column_o); end
        checks++; if (key_code_o !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code_o); end
        checks++; if ({key_valid_o, key_pressed_o, multi_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {key_valid_o, key_pressed_o, multi_o}); end
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (column_o !== 4'b1110) begin errors++; $display("FAIL first_column: got %b expected 1110", column_o); end
        for (int i = 0; i < 4; i++) begin
            strobe();
            checks++; if (column_o !== exp_cols[i]) begin errors++; $display("FAIL column_step%0d: got %b expected %b", i, column_o, exp_cols[i]); end
        end
        checks++; if ({key_valid_o, key_pressed_o, multi_o} !== 3'b000) begin errors++; $display("FAIL idle_flags: got %b expected 000", {key_valid_o, key_pressed_o, multi_o}); end
    endtask

    task automatic test_single_key();
        int v0 = valid_cnt;
        keys = 16'h0200;
        for (int s = 1; s <= 2; s++) begin
            scan();
            checks++; if (key_valid_o !== 1'b0 || valid_cnt != v0) begin errors++; $display("FAIL k9_early_pulse scan%0d: got valid=%b pulses=%0d expected 0/%0d", s, key_valid_o, valid_cnt, v0); end
        end
        scan();
        checks++; if (key_valid_o !== 1'b1) begin errors++; $display("FAIL k9_valid_latency: got %b expected 1", key_valid_o); end
        checks++; if (key_code_o !== 4'd9) begin errors++; $display("FAIL k9_code: got %0d expected 9", key_code_o); end
        checks++; if (key_pressed_o !== 1'b1) begin errors++; $display("FAIL k9_pressed: got %b expected 1", key_pressed_o); end
        @(negedge clk);
        checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL k9_pulse_width: got %b expected 0", key_valid_o); end
        keys = '0;
        for (int s = 1; s <= 2; s++) begin
            scan();
            checks++; if (key_pressed_o !== 1'b1) begin errors++; $display("FAIL k9_release_early scan%0d: got %b expected 1", s, key_pressed_o); end
        end
        scan();
        checks++; if (key_pressed_o !== 1'b0) begin errors++; $display("FAIL k9_released: got %b expected 0", key_pressed_o); end
        @(negedge clk);
        checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL k9_pulse_count: got %0d expected %0d", valid_cnt, v0 + 1); end
    endtask

    task automatic test_bounce();
        int v0 = valid_cnt;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            scan();
            checks++; if (key_pressed_o !== 1'b0) begin errors++; $display("FAIL bounce_pressed scan%0d: got %b expected 0", i, key_pressed_o); end
        end
        @(negedge clk);
        checks++; if (valid_cnt != v0) begin errors++; $display("FAIL bounce_pulses: got %0d expected %0d", valid_cnt, v0); end
    endtask

    task automatic test_multi();
        int v0;
        do_reset();
        v0 = valid_cnt;
        keys = 16'h0021;
        scan();
        scan();
        checks++; if (multi_o !== 1'b0) begin errors++; $display("FAIL multi_early: got %b expected 0", multi_o); end
        scan();
        checks++; if (multi_o !== 1'b1) begin errors++; $display("FAIL multi_set: got %b expected 1", multi_o); end
        checks++; if (key_code_o !== 4'd0 || key_pressed_o !== 1'b0) begin errors++; $display("FAIL multi_code_pressed: got %0d/%b expected 0/0", key_code_o, key_pressed_o); end
        keys = '0;
        scan();
        scan();
        checks++; if (multi_o !== 1'b1) begin errors++; $display("FAIL multi_hold: got %b expected 1", multi_o); end
        scan();
        checks++; if (multi_o !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b expected 0", multi_o); end
        @(negedge clk);
        checks++; if (valid_cnt != v0) begin errors++; $display("FAIL multi_pulses: got %0d expected %0d", valid_cnt, v0); end
    endtask

    task automatic test_no_rollover();
        int v0 = valid_cnt;
        keys = 16'h0200;
        repeat (3) scan();
        checks++; if (key_valid_o !== 1'b1 || key_code_o !== 4'd9) begin errors++; $display("FAIL roll_k9: got valid=%b code=%0d expected 1/9", key_valid_o, key_code_o); end
        keys = 16'h0208;
        scan();
        scan();
        checks++; if (multi_o !== 1'b0 || key_pressed_o !== 1'b1) begin errors++; $display("FAIL roll_early: got multi=%b pressed=%b expected 0/1", multi_o, key_pressed_o); end
        scan();
        checks++; if ({multi_o, key_pressed_o, key_valid_o} !== 3'b100) begin errors++; $display("FAIL roll_multi: got %b expected 100", {multi_o, key_pressed_o, key_valid_o}); end
        checks++; if (key_code_o !== 4'd9) begin errors++; $display("FAIL roll_code_hold: got %0d expected 9", key_code_o); end
        keys = '0;
        repeat (3) scan();
        checks++; if (multi_o !== 1'b0) begin errors++; $display("FAIL roll_release: got %b expected 0", multi_o); end
        keys = 16'h0008;
        repeat (3) scan();
        checks++; if (key_valid_o !== 1'b1 || key_code_o !== 4'd3 || key_pressed_o !== 1'b1) begin errors++; $display("FAIL roll_k3: got valid=%b code=%0d pressed=%b expected 1/3/1", key_valid_o, key_code_o, key_pressed_o); end
        @(negedge clk);
        checks++; if (valid_cnt != v0 + 2) begin errors++; $display("FAIL roll_pulses: got %0d expected %0d", valid_cnt, v0 + 2); end
    endtask

    task automatic test_reset_mid_debounce();
        int v0;
        keys = '0;
        repeat (3) scan();
        checks++; if (key_pressed_o !== 1'b0) begin errors++; $display("FAIL rst_pre_release: got %b expected 0", key_pressed_o); end
        v0 = valid_cnt;
        keys = 16'h0200;
        scan();
        scan();
        rst_i = 1'b0;
        p1pps = 1'b1;
        @(negedge clk);
        p1pps = 1'b0;
        @(negedge clk);
        checks++; if (column_o !== 4'b1111 || key_code_o !== 4'd0) begin errors++; $display("FAIL rst_mid_state: got col=%b code=%0d expected 1111/0", column_o, key_code_o); end
        checks++; if ({key_valid_o, key_pressed_o, multi_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000", {key_valid_o, key_pressed_o, multi_o}); end
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (column_o !== 4'b1110) begin errors++; $display("FAIL rst_mid_column: got %b expected 1110", column_o); end
        for (int s = 1; s <= 2; s++) begin
            scan();
            checks++; if (key_valid_o !== 1'b0 || valid_cnt != v0) begin errors++; $display("FAIL rst_fresh_early scan%0d: got valid=%b pulses=%0d expected 0/%0d", s, key_valid_o, valid_cnt, v0); end
        end
        scan();
        checks++; if (key_valid_o !== 1'b1 || key_code_o !== 4'd9) begin errors++; $display("FAIL rst_fresh_accept: got valid=%b code=%0d expected 1/9", key_valid_o, key_code_o); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_no_rollover();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
